// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
//   Frames are start bit, DATA_BITS data bits (LSB first), an optional parity bit,
//   then STOP_BITS stop bits. Each bit lasts CLK_FREQ/UART_BAUD clocks. When the
//   FIFO still holds data, a new frame starts straight after the last stop clock.
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset; aborts any frame and empties the FIFO
//   TX_DV      write strobe; a word is accepted when TX_DV && TX_READY
//   TX_BYTE    data word to queue
//   TX_READY   FIFO not full
//   TX_DATA    registered serial line, idles high
//   BUSY       transmitter not idle
//   DONE       one-clock pulse on the last clock of each frame's final stop bit
//   FIFO_COUNT number of occupied FIFO entries
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int UART_BAUD  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          TX_DV,
  input  logic [DATA_BITS-1:0]          TX_BYTE,
  output logic                          TX_READY,
  output logic                          TX_DATA,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int CPB       = CLK_FREQ / UART_BAUD;
  localparam int STOP_CLKS = STOP_BITS * CPB;
  // One clock counter serves every state; the stop period is the longest one.
  localparam int CW        = $clog2(STOP_CLKS);
  localparam int BW        = $clog2(DATA_BITS);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int NW        = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]        count_q, count_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign empty    = (count_q == '0);
  // Ready comes from the registered count only, so a write while full is
  // dropped even if the FSM pops on the same edge.
  assign TX_READY = (count_q != DEPTH_N);
  assign push     = TX_DV && TX_READY;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + NW'(1);
    else if (!push && pop) count_d = count_q - NW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= TX_BYTE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------- transmitter FSM ----------------
  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ ODD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                        bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == STOP_LAST) begin
          clk_cnt_d = '0;
          // Chain straight into the next frame to avoid an idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (^head) ^ ODD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so TX_DATA changes on the same edge
    // as the state register.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX_DATA    = tx_q;
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = (state_q == S_STOP) && (clk_cnt_q == STOP_LAST);
  assign FIFO_COUNT = count_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter: configurable clock frequency, baud rate, data width, parity and stop bits, with a small input FIFO.
- Sits between an on-chip byte producer and the TX pin.
- Gives back-to-back frames with no idle gap, and a per-frame completion pulse.

Parameters:
- CLK_FREQ, 12_000_000: input clock frequency in Hz.
- UART_BAUD, 9600: line rate. CLKS_PER_BIT = CLK_FREQ / UART_BAUD (integer division, must be >= 2).
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries in the input FIFO; power of two, >= 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- TX_DV  in  1  write strobe for TX_BYTE.
- TX_BYTE  in  DATA_BITS  data word to queue.
- TX_READY  out  1  FIFO not full; a write is accepted when TX_DV && TX_READY.
- TX_DATA  out  1  serial line, idles high.
- BUSY  out  1  FSM not in IDLE.
- DONE  out  1  one-cycle pulse on the last clock of the final stop bit of every frame.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (RST high at a CLK edge) forces, from the next cycle:
  - FIFO empty; FIFO_COUNT = 0; TX_READY = 1.
  - State IDLE; TX_DATA = 1; BUSY = 0; DONE = 0.
  - Bit and clock counters = 0.
- Reset mid-frame aborts the frame: line returns high the next cycle, no DONE, queued words discarded.
- FIFO:
  - TX_READY = (FIFO_COUNT != FIFO_DEPTH), from registered count.
  - TX_DV while full is ignored, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If FIFO non-empty: pop head into the shift register, go to START.
  - TX_DATA high while in IDLE.
- START: TX_DATA = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - TX_DATA = shift[0], LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After DATA_BITS bits: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Even: bit = XOR of the data bits. Odd: inverted XOR.
  - Held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - TX_DATA = 1 for STOP_BITS * CLKS_PER_BIT cycles.
  - On the last cycle, DONE = 1.
  - Next state is START (popping the next word the same edge) if FIFO non-empty, else IDLE. No idle cycle between frames.
- Latency:
  - Word accepted at edge N into an empty FIFO with the FSM in IDLE: pop and START entry occur at edge N+1.
  - TX_DATA is low from edge N+1.
- Every bit period is exactly CLKS_PER_BIT clocks. Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
- TX_DATA is a registered output; no glitches.
- Counters are sized by $clog2 of their maximum count. No counter overflows for legal parameters.
- TX_BYTE bits above DATA_BITS do not exist; the port width equals DATA_BITS.

Test Plan:
- CLK_FREQ=12e6, UART_BAUD=1e6 (12 clk/bit), 8N1. Write 0x55 once:
  - TX_DATA low 12 clk, then bits 1,0,1,0,1,0,1,0 at 12 clk each, then high 12 clk.
  - DONE pulses once at clock 120 of the frame.
  - BUSY high for 120 clk.
- 7E2 config (DATA_BITS=7, PARITY=2, STOP_BITS=2), write 0x13 (three ones):
  - Parity bit = 1.
  - Frame is 11 bits = 132 clk; stop high for 24 clk.
- Odd parity, 8 bits, write 0xFF:
  - Parity bit = 1.
  - Write 0xFE: parity bit = 0.
- FIFO_DEPTH=4, 8N1. Write 6 words on consecutive cycles while idle:
  - First pops immediately; next 4 accepted; the sixth is rejected (TX_READY=0).
  - Exactly 5 frames come out back-to-back with no high gap beyond stop bits.
  - 5 DONE pulses.
- Assert RST for 1 cycle at clock 50 of a frame with 2 words queued:
  - TX_DATA = 1, BUSY = 0, FIFO_COUNT = 0 next cycle.
  - No DONE; line stays high.
- Simultaneous TX_DV and pop at FIFO_COUNT=2:
  - Count stays 2.
  - Order of transmitted words matches write order.
